booth_multiplier: RTL and testbench
===================================

Name: booth_multiplier

Overview:
- Sequential signed multiplier using radix-4 Booth (bit-pair) recoding; the multiply counterpart to the team's restoring divider in the ALU datapath.
- Takes two WIDTH-bit two's-complement operands and produces a 2*WIDTH-bit product on the same 64-bit result bus the divider drives.
- Retires one bit-pair per clock, so a 32-bit multiply takes 16 iterations.
- Uses a start/busy/done handshake so the ALU control unit can stall cleanly.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a multiply; sampled only in IDLE
- multiplicand  input  WIDTH  signed operand M; sampled with start
- multiplier  input  WIDTH  signed operand Q; sampled with start
- busy  output  1  high in RUN and DONE
- done  output  1  single-cycle pulse; result is valid in that cycle
- result  output  2*WIDTH  signed product M*Q; held until the next accepted start

Behaviour:
- Reset (synchronous, active-high) at any time, including mid-RUN:
  - state goes to IDLE, iteration counter to 0;
  - busy=0, done=0, result=0, internal operand registers = 0;
  - an in-flight operation is discarded without a done pulse.
- State IDLE:
  - busy=0, done=0.
  - start=1 at edge N: latch M, sign-extended to 2*WIDTH; latch Q with appended bit q[-1]=0.
  - Accumulator := 0, count := 0, go to RUN.
  - result keeps its previous value.
- State RUN:
  - busy=1.
  - At each edge, take triple t = {q[2i+1], q[2i], q[2i-1]} with i=count.
  - Recode t to digit d: 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
  - Accumulator += (d*M) << 2i, computed modulo 2^(2*WIDTH).
  - A shifting-accumulator formulation is permitted if bit-exact.
  - count increments each edge.
  - When count == WIDTH/2-1: write the final sum to result and go to DONE.
- State DONE:
  - busy=1, done=1 for exactly one cycle; next edge goes to IDLE.
- Latency: start sampled at edge N -> done=1 in the cycle after edge N+WIDTH/2; for WIDTH=32, after edge N+16.
  - Back-to-back accepted starts are therefore WIDTH/2+2 cycles apart.
- start while busy (RUN or DONE) is ignored; operand inputs may change freely while busy.
- start and reset in the same cycle: reset wins.
- Arithmetic:
  - product is the exact signed result; fits in 2*WIDTH bits for all inputs, including M=Q=-2^(WIDTH-1);
  - -2*M must be formed from the 2*WIDTH sign-extended M so M=-2^(WIDTH-1) does not overflow.
- No X on any output after reset.

Decomposition:
- Shared package mul_pkg:
  - state encoding IDLE/RUN/DONE;
  - Booth digit type (select 0/1x/2x plus negate flag);
  - the 3-bit recoding constants.
- One natural sub-module: booth_recoder, combinational, 3-bit triple in, {zero, two, neg} out; reusable by a future array multiplier.
- Accumulator, counter and FSM stay in the top module.

Test Plan:
- Small positives: reset, start with M=7, Q=3 -> done after 16 iterations; result=0x0000000000000015; busy high for exactly 17 cycles.
- Mixed signs: M=-5 (0xFFFFFFFB), Q=3 -> result=0xFFFFFFFFFFFFFFF1; M=-1, Q=-1 -> result=0x0000000000000001.
- Extremes:
  - M=Q=0x80000000 -> result=0x4000000000000000;
  - M=0x7FFFFFFF, Q=0x80000000 -> result=0xC000000080000000;
  - M=0, Q=0xFFFFFFFF -> result=0.
- Ignored start: assert start with M=9, Q=9 during RUN of 7*3 -> result=0x15, only one done pulse; the following IDLE start with 9*9 -> 0x51.
- Reset mid-operation: reset at iteration 8 of 7*3 -> next cycle busy=0, result=0, no done pulse; a subsequent 2*2 -> result=4 with normal latency.
- Randomized cross-check: 1000 random signed operand pairs -> result equals the 64-bit reference product; done is always exactly one cycle wide.

Source files
------------

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the radix-4 Booth multiplier:
//                FSM state encoding, Booth digit type and the 3-bit recoding
//                triples.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // Booth digit: magnitude select (zero / 1x / 2x) plus negate flag
  typedef struct packed {
    logic zero;
    logic two;
    logic neg;
  } booth_digit_t;

  // Recoding triples {q[2i+1], q[2i], q[2i-1]}
  localparam logic [2:0] TRIPLE_Z0  = 3'b000;  // digit  0
  localparam logic [2:0] TRIPLE_P1A = 3'b001;  // digit +1
  localparam logic [2:0] TRIPLE_P1B = 3'b010;  // digit +1
  localparam logic [2:0] TRIPLE_P2  = 3'b011;  // digit +2
  localparam logic [2:0] TRIPLE_M2  = 3'b100;  // digit -2
  localparam logic [2:0] TRIPLE_M1A = 3'b101;  // digit -1
  localparam logic [2:0] TRIPLE_M1B = 3'b110;  // digit -1
  localparam logic [2:0] TRIPLE_Z1  = 3'b111;  // digit  0

endpackage
`default_nettype wire

// File: rtl/booth_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier_if
//  Description : start/busy/done handshake plus operand and result buses
//                between the ALU control unit and the Booth multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
interface booth_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;

  // Requester side (ALU control unit)
  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, result
  );

  // Multiplier side
  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, result
  );
endinterface
`default_nettype wire

// File: rtl/booth_recoder.sv
`default_nettype none
// ============================================================================
//  Module      : booth_recoder
//  Description : Combinational radix-4 Booth recoder. Maps a 3-bit multiplier
//                triple to a signed digit in {-2,-1,0,+1,+2}, expressed as
//                {zero, two, neg}.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_recoder
  import mul_pkg::*;
(
  input  wire logic [2:0]   triple_i,
  output booth_digit_t      digit_o
);

  // Table lookup of the Booth digit for the current bit-pair
  always_comb begin
    digit_o = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
    case (triple_i)
      TRIPLE_Z0, TRIPLE_Z1:   digit_o = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
      TRIPLE_P1A, TRIPLE_P1B: digit_o = '{zero: 1'b0, two: 1'b0, neg: 1'b0};
      TRIPLE_P2:              digit_o = '{zero: 1'b0, two: 1'b1, neg: 1'b0};
      TRIPLE_M2:              digit_o = '{zero: 1'b0, two: 1'b1, neg: 1'b1};
      TRIPLE_M1A, TRIPLE_M1B: digit_o = '{zero: 1'b0, two: 1'b0, neg: 1'b1};
      default:                digit_o = '{zero: 1'b1, two: 1'b0, neg: 1'b0};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier
//  Description : Sequential signed radix-4 Booth multiplier. One bit-pair is
//                retired per clock; a WIDTH-bit multiply takes WIDTH/2
//                iterations followed by a one-cycle DONE state.
//                WIDTH must be even and >= 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  wire logic         clk,
  input  wire logic         reset,
  booth_multiplier_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH / 2 - 1);

  mul_state_t      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  // Multiplicand, sign-extended to full product width and pre-shifted by 2i
  logic [PW-1:0]   m_q, m_d;
  // Multiplier with q[-1] appended at bit 0; shifted right two bits per step
  // so the current triple always sits in bits [2:0]
  logic [WIDTH:0]  q_q, q_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   result_q, result_d;

  booth_digit_t    digit;
  logic [PW-1:0]   pp_mag;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   acc_sum;

  booth_recoder u_recoder (
    .triple_i (q_q[2:0]),
    .digit_o  (digit)
  );

  // Partial product d*M*4^i; 2x and negation are taken on the full-width
  // sign-extended M, so the most negative operand cannot overflow
  always_comb begin
    pp_mag  = digit.zero ? '0 : (digit.two ? {m_q[PW-2:0], 1'b0} : m_q);
    pp      = digit.neg ? (-pp_mag) : pp_mag;
    acc_sum = acc_q + pp;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      m_q      <= '0;
      q_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      m_q      <= m_d;
      q_q      <= q_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    m_d      = m_q;
    q_d      = q_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          m_d     = {{WIDTH{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
          q_d     = {bus.multiplier, 1'b0};
          acc_d   = '0;
          count_d = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d   = acc_sum;
        m_d     = {m_q[PW-3:0], 2'b00};
        q_d     = {2'b00, q_q[WIDTH:2]};
        count_d = count_q + 1'b1;
        if (count_q == LAST_ITER) begin
          result_d = acc_sum;
          count_d  = '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = (state_q == ST_DONE);
  assign bus.result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_booth_multiplier
//  Description : Self-checking bench for booth_multiplier (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH / 2 + 1;   // cycle index of done after start edge

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  booth_multiplier_if #(.WIDTH(WIDTH)) bus ();

  booth_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  // Issue one multiply and follow it until the multiplier returns to idle.
  // inject_at > 0 asserts start with 9*9 during that busy cycle.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input int inject_at,
                        output logic [63:0] res, output int busy_n, output int done_n,
                        output int done_at, output logic [63:0] held);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = m;
    bus.multiplier   = q;
    @(negedge clk);
    bus.start        = 1'b0;
    bus.multiplicand = $urandom;
    bus.multiplier   = $urandom;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    res     = '0;
    held    = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (done_at < 0) done_at = k;
        res = bus.result;
      end
      if (!bus.busy && k > 1) begin
        held = bus.result;
        break;
      end
      if (k == inject_at) begin
        bus.start        = 1'b1;
        bus.multiplicand = 32'd9;
        bus.multiplier   = 32'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] held;
    logic [31:0] rm;
    logic [31:0] rq;
    int busy_n;
    int done_n;
    int done_at;
    int seen_done;

    checks   = 0;
    failures = 0;

    vecs[0] = '{32'd7,        32'd3,        64'h0000000000000015};
    vecs[1] = '{32'hFFFFFFFB, 32'd3,        64'hFFFFFFFFFFFFFFF1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[3] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[4] = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
    vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 64'h0000000000000000};

    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    reset            = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("reset_busy",   64'(bus.busy),   64'd0);
    check("reset_done",   64'(bus.done),   64'd0);
    check("reset_result", bus.result,      64'd0);

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].m, vecs[i].q, 0, res, busy_n, done_n, done_at, held);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_done_cnt", i), 64'(done_n), 64'd1);
      check($sformatf("vec%0d_done_at", i), 64'(done_at), 64'(LAT));
      check($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'(LAT));
      check($sformatf("vec%0d_held", i), held, vecs[i].exp);
    end

    // Start during RUN is ignored
    run_op(32'd7, 32'd3, 5, res, busy_n, done_n, done_at, held);
    check("ignored_start_result", res, 64'h15);
    check("ignored_start_done_cnt", 64'(done_n), 64'd1);
    check("ignored_start_busy", 64'(busy_n), 64'(LAT));
    run_op(32'd9, 32'd9, 0, res, busy_n, done_n, done_at, held);
    check("after_ignored_result", res, 64'h51);

    // Reset mid-operation, with start asserted alongside reset
    seen_done = 0;
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier   = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 9; k++) begin
      if (bus.done) seen_done++;
      @(negedge clk);
    end
    reset            = 1'b1;
    bus.start        = 1'b1;
    bus.multiplicand = 32'd5;
    bus.multiplier   = 32'd5;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    check("midreset_busy",   64'(bus.busy), 64'd0);
    check("midreset_done",   64'(bus.done), 64'd0);
    check("midreset_result", bus.result,    64'd0);
    for (int k = 0; k < 20; k++) begin
      if (bus.done || bus.busy) seen_done++;
      @(negedge clk);
    end
    check("midreset_no_done", 64'(seen_done), 64'd0);
    run_op(32'd2, 32'd2, 0, res, busy_n, done_n, done_at, held);
    check("post_reset_result",  res, 64'd4);
    check("post_reset_done_at", 64'(done_at), 64'(LAT));

    // Randomized cross-check against arithmetic reference
    for (int n = 0; n < 1000; n++) begin
      rm = $urandom;
      rq = $urandom;
      case ($urandom_range(0, 7))
        0: rm = 32'h80000000;
        1: rq = 32'h80000000;
        2: rm = 32'h7FFFFFFF;
        default: ;
      endcase
      run_op(rm, rq, 0, res, busy_n, done_n, done_at, held);
      check($sformatf("rand%0d_result m=%h q=%h", n, rm, rq), res, ref_mul(rm, rq));
      check($sformatf("rand%0d_done_cnt", n), 64'(done_n), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
